// File: rtl/arcade_input_mapper.sv
// Joystick-to-cabinet input mapper for N-player arcade cores.
// Registered direction/start outputs, SOCD filtering, queued coin pulse shaping.
module arcade_input_mapper #(
    parameter int NUM_PLAYERS   = 2,
    parameter int COIN_HIGH_CYC = 2400000,
    parameter int COIN_LOW_CYC  = 2400000,
    parameter int COIN_QDEPTH   = 3
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [32*NUM_PLAYERS-1:0]  joystick_in,
    input  logic                       twin_mode,
    input  logic                       cocktail,
    input  logic                       socd_en,
    output logic [4*NUM_PLAYERS-1:0]   l_dir,
    output logic [4*NUM_PLAYERS-1:0]   r_dir,
    output logic [NUM_PLAYERS-1:0]     start,
    output logic [NUM_PLAYERS-1:0]     coin,
    output logic [NUM_PLAYERS-1:0]     coin_busy
);

    localparam int NW   = 2 * NUM_PLAYERS;
    localparam int CMAX = (COIN_HIGH_CYC > COIN_LOW_CYC) ?
                          COIN_HIGH_CYC : COIN_LOW_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int QW   = $clog2(COIN_QDEPTH + 1);

    localparam logic [CW-1:0] HIGH_LAST = CW'(COIN_HIGH_CYC - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(COIN_LOW_CYC - 1);
    localparam logic [QW-1:0] QMAX      = QW'(COIN_QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } coin_state_t;

    coin_state_t              r_state [NUM_PLAYERS];
    logic [CW-1:0]            r_cnt   [NUM_PLAYERS];
    logic [QW-1:0]            r_q     [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]   r_cprev;

    logic [3:0]               w_l_or;
    logic [3:0]               w_r_or;
    logic [3:0]               w_r_src [NUM_PLAYERS];
    logic                     w_s8_or;
    logic                     w_s9_or;
    logic                     w_c_or;
    logic                     w_unused;
    logic [4*NUM_PLAYERS-1:0] w_l_nxt;
    logic [4*NUM_PLAYERS-1:0] w_r_nxt;
    logic [NUM_PLAYERS-1:0]   w_start_nxt;
    logic [NUM_PLAYERS-1:0]   w_csrc;
    logic [NUM_PLAYERS-1:0]   w_edge;
    logic [NUM_PLAYERS-1:0]   w_deq;
    logic [NUM_PLAYERS-1:0]   w_inc;

    // Opposing directions cancel: bit0 R / bit1 L, bit2 D / bit3 U.
    function automatic logic [3:0] socd(input logic [3:0] d, input logic en);
        logic [3:0] o;
        o = d;
        if (en && d[0] && d[1]) o[1:0] = 2'b00;
        if (en && d[2] && d[3]) o[3:2] = 2'b00;
        return o;
    endfunction

    always_comb begin
        w_l_or      = '0;
        w_r_or      = '0;
        w_s8_or     = 1'b0;
        w_s9_or     = 1'b0;
        w_c_or      = 1'b0;
        w_unused    = 1'b0;
        w_l_nxt     = '0;
        w_r_nxt     = '0;
        w_start_nxt = '0;
        w_csrc      = '0;
        for (int i = 0; i < NW; i++) begin
            w_s8_or  = w_s8_or | joystick_in[16*i+8];
            w_s9_or  = w_s9_or | joystick_in[16*i+9];
            w_c_or   = w_c_or  | joystick_in[16*i+10];
            w_unused = w_unused ^ (^joystick_in[16*i+4 +: 12]);
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_r_src[p] = twin_mode ?
                joystick_in[16*(NUM_PLAYERS+p) +: 4] :
                (joystick_in[16*p+4 +: 4] |
                 joystick_in[16*(NUM_PLAYERS+p) +: 4]);
            w_l_or = w_l_or | joystick_in[16*p +: 4];
            w_r_or = w_r_or | w_r_src[p];
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_l_nxt[4*p +: 4] = socd(cocktail ? joystick_in[16*p +: 4] : w_l_or,
                                     socd_en);
            w_r_nxt[4*p +: 4] = socd(cocktail ? w_r_src[p] : w_r_or, socd_en);
            if (cocktail || p > 1)
                w_start_nxt[p] = joystick_in[16*p+8];
            else
                w_start_nxt[p] = (p == 0) ? w_s8_or : w_s9_or;
            if (cocktail)
                w_csrc[p] = joystick_in[16*p+10];
            else
                w_csrc[p] = (p == 0) ? w_c_or : 1'b0;
        end
    end

    // Saturating queue: an edge is dropped only when full and not draining.
    always_comb begin
        w_edge    = w_csrc & ~r_cprev;
        w_deq     = '0;
        w_inc     = '0;
        coin_busy = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_deq[p]     = (r_state[p] == S_IDLE) && (r_q[p] != '0);
            w_inc[p]     = w_edge[p] && ((r_q[p] != QMAX) || w_deq[p]);
            coin_busy[p] = (r_state[p] != S_IDLE) || (r_q[p] != '0);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            l_dir   <= '0;
            r_dir   <= '0;
            start   <= '0;
            coin    <= '0;
            r_cprev <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_state[p] <= S_IDLE;
                r_cnt[p]   <= '0;
                r_q[p]     <= '0;
            end
        end else begin
            l_dir   <= w_l_nxt;
            r_dir   <= w_r_nxt;
            start   <= w_start_nxt;
            r_cprev <= w_csrc;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_q[p] <= r_q[p] + QW'(w_inc[p]) - QW'(w_deq[p]);
                unique case (r_state[p])
                    S_IDLE: begin
                        if (w_deq[p]) begin
                            r_state[p] <= S_PULSE;
                            coin[p]    <= 1'b1;
                            r_cnt[p]   <= '0;
                        end
                    end
                    S_PULSE: begin
                        if (r_cnt[p] == HIGH_LAST) begin
                            r_state[p] <= S_GAP;
                            coin[p]    <= 1'b0;
                            r_cnt[p]   <= '0;
                        end else begin
                            r_cnt[p] <= r_cnt[p] + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt[p] == LOW_LAST) begin
                            r_state[p] <= S_IDLE;
                            r_cnt[p]   <= '0;
                        end else begin
                            r_cnt[p] <= r_cnt[p] + 1'b1;
                        end
                    end
                    default: begin
                        r_state[p] <= S_IDLE;
                        coin[p]    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: vector table, coin sequences, random run
// against a timestamp-based behavioural model.
module tb_arcade_input_mapper;

    localparam int NP = 2;
    localparam int H  = 5;
    localparam int L  = 3;
    localparam int QD = 3;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [63:0] joy;
    logic        twin, cock, socd;
    logic [7:0]  l_dir, r_dir;
    logic [1:0]  start, coin, coin_busy;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NUM_PLAYERS  (NP),
        .COIN_HIGH_CYC(H),
        .COIN_LOW_CYC (L),
        .COIN_QDEPTH  (QD)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .joystick_in(joy),
        .twin_mode  (twin),
        .cocktail   (cock),
        .socd_en    (socd),
        .l_dir      (l_dir),
        .r_dir      (r_dir),
        .start      (start),
        .coin       (coin),
        .coin_busy  (coin_busy)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: expected registered outputs plus coin timestamps.
    logic [7:0] m_l, m_r;
    logic [1:0] m_start;
    int         m_q    [NP];
    bit         m_prev [NP];
    int         m_st   [NP];
    int         m_free [NP];
    int         m_t  = 0;
    int         m_tl = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] f_socd(input logic [3:0] d);
        logic [3:0] o;
        o = d;
        if (socd) begin
            if (d[0] && d[1]) o[1:0] = 2'b00;
            if (d[2] && d[3]) o[3:2] = 2'b00;
        end
        return o;
    endfunction

    task automatic model_reset();
        m_l = '0;
        m_r = '0;
        m_start = '0;
        for (int p = 0; p < NP; p++) begin
            m_q[p]    = 0;
            m_prev[p] = 1'b0;
            m_st[p]   = -1000000;
            m_free[p] = 0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] w [2*NP];
        logic [3:0]  lor, ror;
        logic [3:0]  rs [NP];
        bit          s8, s9, cor, e, d;
        bit          c [NP];
        lor = '0; ror = '0; s8 = 0; s9 = 0; cor = 0;
        for (int j = 0; j < 2*NP; j++) begin
            w[j] = joy[16*j +: 16];
            s8  |= w[j][8];
            s9  |= w[j][9];
            cor |= w[j][10];
        end
        for (int p = 0; p < NP; p++) begin
            rs[p] = twin ? w[NP+p][3:0] : (w[p][7:4] | w[NP+p][3:0]);
            lor |= w[p][3:0];
            ror |= rs[p];
        end
        for (int p = 0; p < NP; p++) begin
            m_l[4*p +: 4] = f_socd(cock ? w[p][3:0] : lor);
            m_r[4*p +: 4] = f_socd(cock ? rs[p] : ror);
            if (cock || p > 1) m_start[p] = w[p][8];
            else               m_start[p] = (p == 0) ? s8 : s9;
            c[p] = cock ? w[p][10] : ((p == 0) ? cor : 1'b0);
        end
        // A pulse may start once the previous high+low window has elapsed.
        for (int p = 0; p < NP; p++) begin
            e = c[p] && !m_prev[p];
            m_prev[p] = c[p];
            d = (m_t >= m_free[p]) && (m_q[p] > 0);
            if (d) begin
                m_st[p]   = m_t;
                m_free[p] = m_t + H + L + 1;
            end
            m_q[p] = m_q[p] + int'(e) - int'(d);
            if (m_q[p] > QD) m_q[p] = QD;
        end
        m_tl = m_t;
        m_t++;
    endtask

    task automatic check_all();
        logic [1:0] ec, eb;
        for (int p = 0; p < NP; p++) begin
            ec[p] = (m_tl >= m_st[p]) && (m_tl < m_st[p] + H);
            eb[p] = ((m_tl >= m_st[p]) && (m_tl < m_st[p] + H + L)) ||
                    (m_q[p] != 0);
        end
        if (!reset_n) begin
            ec = '0;
            eb = '0;
        end
        chk("l_dir", 32'(l_dir), 32'(m_l));
        chk("r_dir", 32'(r_dir), 32'(m_r));
        chk("start", 32'(start), 32'(m_start));
        chk("coin", 32'(coin), 32'(ec));
        chk("coin_busy", 32'(coin_busy), 32'(eb));
    endtask

    task automatic tick();
        @(posedge clk_sys);
        if (reset_n) model_edge();
        else         model_reset();
        #1;
        check_all();
    endtask

    // Pulse-shape observer on coin[0].
    int o_pulses, o_hi, o_lo, o_mingap, o_badw, o_lastw;
    bit o_prev;

    task automatic obs_reset();
        o_pulses = 0; o_hi = 0; o_lo = 0; o_mingap = 1000;
        o_badw = 0; o_lastw = 0; o_prev = 1'b0;
    endtask

    task automatic observe();
        if (coin[0]) begin
            if (!o_prev) begin
                o_pulses++;
                if (o_pulses > 1 && o_lo < o_mingap) o_mingap = o_lo;
                o_hi = 0;
            end
            o_hi++;
        end else begin
            if (o_prev) begin
                o_lastw = o_hi;
                if (o_hi != H) o_badw++;
                o_lo = 0;
            end
            o_lo++;
        end
        o_prev = coin[0];
    endtask

    task automatic run_obs(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            observe();
        end
    endtask

    typedef struct {
        logic [63:0] joy;
        bit          tw, ck, sd;
        logic [7:0]  el, er;
        logic [1:0]  es;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int   rises1;
        bit   seen;
        logic c1p;

        tbl[0] = '{64'h0000_0000_0008_0020, 0, 0, 0, 8'h88, 8'h22, 2'b00};
        tbl[1] = '{64'h0000_0000_0008_0020, 1, 0, 0, 8'h88, 8'h00, 2'b00};
        tbl[2] = '{64'h0000_0002_0008_0020, 1, 0, 0, 8'h88, 8'h22, 2'b00};
        tbl[3] = '{64'h0000_0000_0000_000B, 0, 1, 1, 8'h08, 8'h00, 2'b00};
        tbl[4] = '{64'h0000_0000_0000_000B, 0, 1, 0, 8'h0B, 8'h00, 2'b00};
        tbl[5] = '{64'h0200_0000_0100_0000, 0, 0, 0, 8'h00, 8'h00, 2'b11};
        tbl[6] = '{64'h0000_0000_0100_0200, 0, 1, 0, 8'h00, 8'h00, 2'b10};
        tbl[7] = '{64'h0003_0000_000D_0000, 1, 1, 1, 8'h10, 8'h00, 2'b00};
        tbl[8] = '{64'h0004_0000_0000_0010, 0, 1, 0, 8'h00, 8'h41, 2'b00};

        // Reset with every input active.
        reset_n = 1'b0;
        joy  = '1;
        twin = 1'b1;
        cock = 1'b1;
        socd = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        joy  = '0;
        twin = 1'b0;
        cock = 1'b0;
        socd = 1'b0;
        reset_n = 1'b1;
        tick();
        joy = 64'h1;
        #1;
        chk("l_dir0_before_edge", 32'(l_dir[3:0]), 32'h0);
        tick();
        chk("l_dir0_latency", 32'(l_dir[3:0]), 32'h1);

        for (int i = 0; i < 9; i++) begin
            joy  = tbl[i].joy;
            twin = tbl[i].tw;
            cock = tbl[i].ck;
            socd = tbl[i].sd;
            tick();
            chk($sformatf("vec%0d_l", i), 32'(l_dir), 32'(tbl[i].el));
            chk($sformatf("vec%0d_r", i), 32'(r_dir), 32'(tbl[i].er));
            chk($sformatf("vec%0d_s", i), 32'(start), 32'(tbl[i].es));
        end

        // Single one-cycle press.
        joy = '0; twin = 0; cock = 0; socd = 0;
        run_obs(12);
        obs_reset();
        joy[10] = 1'b1;
        tick(); observe();
        joy[10] = 1'b0;
        run_obs(25);
        chk("single_pulses", 32'(o_pulses), 32'd1);
        chk("single_width", 32'(o_lastw), 32'(H));
        chk("single_busy_end", 32'(coin_busy), 32'h0);

        // Held coin must not retrigger.
        obs_reset();
        joy[10] = 1'b1;
        run_obs(20);
        joy[10] = 1'b0;
        run_obs(20);
        chk("held_pulses", 32'(o_pulses), 32'd1);

        // Five presses, two-cycle spacing: one in flight, three queued, one dropped.
        obs_reset();
        for (int k = 0; k < 5; k++) begin
            joy[10] = 1'b1;
            tick(); observe();
            joy[10] = 1'b0;
            tick(); observe();
        end
        run_obs(60);
        chk("queue_pulses", 32'(o_pulses), 32'd4);
        chk("queue_width_bad", 32'(o_badw), 32'd0);
        chk("queue_gap_ge4", 32'(o_mingap >= L + 1), 32'd1);
        chk("queue_busy_end", 32'(coin_busy), 32'h0);

        // Reset during the second cycle of a pulse.
        joy[10] = 1'b1;
        tick();
        joy[10] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = coin[0];
        end
        chk("rst_pulse_started", 32'(seen), 32'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("coin_async_reset", 32'(coin), 32'h0);
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        obs_reset();
        run_obs(20);
        chk("post_reset_pulses", 32'(o_pulses), 32'd0);

        // Queued coin on player 1 survives a switch to upright.
        cock = 1'b1;
        rises1 = 0;
        c1p = 1'b0;
        joy[26] = 1'b1; tick();
        joy[26] = 1'b0; tick();
        joy[26] = 1'b1; tick();
        joy[26] = 1'b0;
        cock = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (coin[1] && !c1p) rises1++;
            c1p = coin[1];
        end
        chk("upright_switch_p1_pulses", 32'(rises1 + int'(coin[1] === 1'bx)), 32'd2);

        // Random traffic with occasional mode flips.
        for (int i = 0; i < 600; i++) begin
            joy = {$urandom, $urandom};
            for (int j = 0; j < 2*NP; j++)
                joy[16*j+10] = ($urandom_range(15) == 0);
            if ($urandom_range(19) == 0) twin = ~twin;
            if ($urandom_range(19) == 0) cock = ~cock;
            if ($urandom_range(9) == 0)  socd = ~socd;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
